v810_bus_target: RTL and testbench

- Memory-mapped responder on the V810 external bus; the target end of the bus cycles driven by v810_mem.
- Decodes address and MRQn, counts programmable wait states, and bridges one bus cycle to a variable-latency req/ack backing-memory port (ROM/RAM model or SDRAM arbiter).
- Drives READYn and SZRQn with wired-bus-safe idle levels, so several targets can share the wor/wand nets.

---
 rtl/v810_bus_target.sv | 140 ++++++++++++++
 tb/tb_v810_bus_target.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v810_bus_target.sv
// V810 external-bus target: decodes MRQn/address, inserts programmable wait
// states, then bridges the bus cycle onto a req/ack backing-memory port.
// Idle output levels (READYn=0, SZRQn=1, D_O=0) are chosen so several targets
// can share wired-OR / wired-AND bus nets.
//
// Handshake: MEM_REQ rises when the FSM enters REQ and, together with MEM_A,
// MEM_BE, MEM_WE and MEM_DI, holds stable until a CE=1 clock edge samples
// MEM_ACK=1; that edge completes the transfer (and captures MEM_DO on reads).
module v810_bus_target #(
  parameter logic [31:0] BASE = 32'hFFF0_0000,
  parameter logic [31:0] MASK = 32'hFFF0_0000,
  parameter int          DW   = 32,
  parameter int          WS   = 0,
  parameter int          AW   = 20
) (
  input  logic          CLK,
  input  logic          RESn,
  input  logic          CE,
  input  logic [31:0]   A,
  input  logic [31:0]   D_I,
  output logic [31:0]   D_O,
  input  logic [3:0]    BEn,
  input  logic          DAn,
  input  logic          MRQn,
  input  logic          RW,
  input  logic          BCYSTn,
  output logic          READYn,
  output logic          SZRQn,
  output logic [AW-1:0] MEM_A,
  output logic [3:0]    MEM_BE,
  output logic          MEM_WE,
  output logic          MEM_REQ,
  input  logic          MEM_ACK,
  output logic [31:0]   MEM_DI,
  input  logic [31:0]   MEM_DO,
  output logic [1:0]    DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_REQ  = 2'd2,
    ST_RDY  = 2'd3
  } state_t;

  localparam bit         IS16 = (DW == 16);
  localparam logic [3:0] WS4  = 4'(WS);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_mem_a;
  logic [3:0]    r_be;
  logic          r_rw;
  logic [31:0]   r_di;
  logic [31:0]   r_data;

  logic          w_sel;
  logic          w_accept;
  logic          w_lo_half;
  logic [3:0]    w_be;
  logic [31:0]   w_di;

  // Address decode and acceptance of a new bus cycle (only from IDLE).
  always_comb begin
    w_sel     = ((A & MASK) == BASE);
    w_accept  = CE && !BCYSTn && !MRQn && w_sel && (r_state == ST_IDLE);
    w_lo_half = (BEn[1:0] != 2'b11);
    w_be      = ~BEn;
    w_di      = D_I;
    if (IS16) begin
      // A 16-bit device sees one halfword lane: pick the enabled one.
      w_be = {2'b00, w_lo_half ? ~BEn[1:0] : ~BEn[3:2]};
      w_di = {16'h0000, w_lo_half ? D_I[15:0] : D_I[31:16]};
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; every transition is qualified by CE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept)                w_next = (WS4 != 4'd0) ? ST_WAIT : ST_REQ;
      ST_WAIT: if (CE && (r_cnt <= 4'd1))   w_next = ST_REQ;
      ST_REQ:  if (CE && MEM_ACK)           w_next = ST_RDY;
      ST_RDY:  if (CE && !DAn)              w_next = ST_IDLE;
      default:                              w_next = ST_IDLE;
    endcase
  end

  // Wait-state counter: loaded on acceptance, counts down while in WAIT.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn)                             r_cnt <= 4'd0;
    else if (w_accept)                     r_cnt <= WS4;
    else if (CE && (r_state == ST_WAIT))   r_cnt <= 4'(r_cnt - 4'd1);
  end

  // Latch the request attributes at acceptance so memory outputs stay stable.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      r_mem_a <= '0;
      r_be    <= 4'h0;
      r_rw    <= 1'b0;
      r_di    <= 32'h0;
    end else if (w_accept) begin
      r_mem_a <= IS16 ? A[AW:1] : A[AW+1:2];
      r_be    <= w_be;
      r_rw    <= RW;
      r_di    <= w_di;
    end
  end

  // Read-data latch, captured on the completing ACK edge.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      r_data <= 32'h0;
    end else if (CE && MEM_ACK && (r_state == ST_REQ) && r_rw) begin
      r_data <= IS16 ? {MEM_DO[15:0], MEM_DO[15:0]} : MEM_DO;
    end
  end

  // Bus and memory outputs; idle levels are wired-bus safe.
  always_comb begin
    MEM_REQ   = (r_state == ST_REQ);
    MEM_A     = r_mem_a;
    MEM_BE    = MEM_REQ ? r_be : 4'h0;
    MEM_WE    = MEM_REQ && !r_rw;
    MEM_DI    = r_di;
    READYn    = (r_state == ST_WAIT) || (r_state == ST_REQ);
    SZRQn     = !(IS16 && ((r_state != ST_IDLE) || w_accept));
    D_O       = ((r_state == ST_RDY) && r_rw && !DAn) ? r_data : 32'h0;
    DBG_STATE = r_state;
  end

endmodule

// File: tb/tb_v810_bus_target.sv
// Bench for v810_bus_target: three targets share one wired bus
//   u_t0: DW=32 WS=0 at FFF0_0000, u_t1: DW=32 WS=3 at FFE0_0000,
//   u_t2: DW=16 WS=0 at FFD0_0000.
// MEM_A follows the full A[AW+1:2] / A[AW:1] slice, so base bits above the
// low offset show up in the expected word addresses.
module tb_v810_bus_target;

  logic        CLK = 1'b0;
  logic        RESn = 1'b0;
  logic        CE = 1'b1;
  logic [31:0] A = 32'h0;
  logic [31:0] D_I = 32'h0;
  logic [3:0]  BEn = 4'hF;
  logic        DAn = 1'b1;
  logic        MRQn = 1'b1;
  logic        RW = 1'b1;
  logic        BCYSTn = 1'b1;
  logic        MEM_ACK = 1'b0;
  logic [31:0] MEM_DO = 32'h0;

  logic [31:0] d_o    [3];
  logic        readyn [3];
  logic        szrqn  [3];
  logic [19:0] mem_a  [3];
  logic [3:0]  mem_be [3];
  logic        mem_we [3];
  logic        mem_req[3];
  logic [31:0] mem_di [3];
  logic [1:0]  dbg    [3];

  // wired bus views and the active memory port
  logic        readyn_bus, szrq_bus, req_any;
  logic [31:0] do_bus;
  logic [57:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  logic [57:0] exp_mem_q[$];
  logic [31:0] exp_rsp_q[$];

  logic        ce_toggle = 1'b0;
  logic        prev_ce = 1'b1;
  logic        resp_en = 1'b1;
  int          ack_delay = 0;
  logic [31:0] mem_rdata = 32'h0;

  v810_bus_target #(.BASE(32'hFFF0_0000), .MASK(32'hFFF0_0000), .DW(32), .WS(0), .AW(20)) u_t0 (
    .CLK(CLK), .RESn(RESn), .CE(CE), .A(A), .D_I(D_I), .D_O(d_o[0]), .BEn(BEn), .DAn(DAn),
    .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(readyn[0]), .SZRQn(szrqn[0]),
    .MEM_A(mem_a[0]), .MEM_BE(mem_be[0]), .MEM_WE(mem_we[0]), .MEM_REQ(mem_req[0]),
    .MEM_ACK(MEM_ACK), .MEM_DI(mem_di[0]), .MEM_DO(MEM_DO), .DBG_STATE(dbg[0]));

  v810_bus_target #(.BASE(32'hFFE0_0000), .MASK(32'hFFF0_0000), .DW(32), .WS(3), .AW(20)) u_t1 (
    .CLK(CLK), .RESn(RESn), .CE(CE), .A(A), .D_I(D_I), .D_O(d_o[1]), .BEn(BEn), .DAn(DAn),
    .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(readyn[1]), .SZRQn(szrqn[1]),
    .MEM_A(mem_a[1]), .MEM_BE(mem_be[1]), .MEM_WE(mem_we[1]), .MEM_REQ(mem_req[1]),
    .MEM_ACK(MEM_ACK), .MEM_DI(mem_di[1]), .MEM_DO(MEM_DO), .DBG_STATE(dbg[1]));

  v810_bus_target #(.BASE(32'hFFD0_0000), .MASK(32'hFFF0_0000), .DW(16), .WS(0), .AW(20)) u_t2 (
    .CLK(CLK), .RESn(RESn), .CE(CE), .A(A), .D_I(D_I), .D_O(d_o[2]), .BEn(BEn), .DAn(DAn),
    .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn), .READYn(readyn[2]), .SZRQn(szrqn[2]),
    .MEM_A(mem_a[2]), .MEM_BE(mem_be[2]), .MEM_WE(mem_we[2]), .MEM_REQ(mem_req[2]),
    .MEM_ACK(MEM_ACK), .MEM_DI(mem_di[2]), .MEM_DO(MEM_DO), .DBG_STATE(dbg[2]));

  // clock / reset block
  always #5 CLK = ~CLK;

  always_comb begin
    readyn_bus = readyn[0] | readyn[1] | readyn[2];
    szrq_bus   = szrqn[0] & szrqn[1] & szrqn[2];
    do_bus     = d_o[0] | d_o[1] | d_o[2];
    req_any    = mem_req[0] | mem_req[1] | mem_req[2];
    obs        = {mem_a[2], mem_be[2], mem_we[2], mem_di[2], szrq_bus};
    if (mem_req[0])      obs = {mem_a[0], mem_be[0], mem_we[0], mem_di[0], szrq_bus};
    else if (mem_req[1]) obs = {mem_a[1], mem_be[1], mem_we[1], mem_di[1], szrq_bus};
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge CLK);
    prev_ce = CE;
    CE = ce_toggle ? ~CE : 1'b1;
  endtask

  task automatic wait_ce();
    step();
    for (int k = 0; k < 4 && CE !== 1'b1; k++) step();
  endtask

  task automatic bus_cycle(input string name, input logic [31:0] a, input logic [3:0] ben,
                           input logic rw, input logic [31:0] di, input logic [31:0] rdata,
                           input int ackd, input logic [57:0] exp_mem,
                           input logic [31:0] exp_do, input int exp_lat);
    int  lat;
    bit  done;
    mem_rdata = rdata;
    ack_delay = ackd;
    exp_mem_q.push_back(exp_mem);
    exp_rsp_q.push_back(exp_do);
    wait_ce();
    A = a; BEn = ben; RW = rw; D_I = di; MRQn = 1'b0; BCYSTn = 1'b0; DAn = 1'b1;
    step();
    BCYSTn = 1'b1; MRQn = 1'b1; DAn = 1'b0;
    lat = 1;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (readyn_bus === 1'b0) done = 1'b1;
      else begin
        step();
        if (prev_ce) lat++;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no READYn=0 expected completion within 200 cycles", name);
    end else begin
      if (exp_lat >= 0) chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({name, "_ce_edge"}, 64'(prev_ce), 64'd1);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (prev_ce) break;
    end
    DAn = 1'b1;
    #1;
    chk({name, "_idle_after"}, {readyn_bus, do_bus, dbg[0], dbg[1], dbg[2]}, 64'h0);
  endtask

  task automatic idle_cycle(input string name, input logic [31:0] a, input logic mrqn);
    wait_ce();
    A = a; MRQn = mrqn; BCYSTn = 1'b0; RW = 1'b1; BEn = 4'h0; DAn = 1'b1;
    #1;
    chk({name, "_accept"}, {readyn_bus, szrq_bus, do_bus, req_any}, {1'b0, 1'b1, 32'h0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      step();
      BCYSTn = 1'b1; MRQn = 1'b1; DAn = 1'b0;
      #1;
      chk({name, "_cycle"}, {readyn_bus, szrq_bus, do_bus, req_any}, {1'b0, 1'b1, 32'h0, 1'b0});
    end
    DAn = 1'b1;
  endtask

  // memory responder: ACK after ack_delay counted CE edges, held until a CE=1 edge
  initial begin
    int ack_wait;
    logic ce_now;
    ack_wait = 0;
    forever begin
      @(posedge CLK);
      #1;
      ce_now = CE;
      if (!resp_en) ack_wait = 0;
      else if (MEM_ACK) begin
        if (ce_now) MEM_ACK = 1'b0;
      end else if (req_any) begin
        if (ack_wait >= ack_delay) begin
          MEM_ACK = 1'b1;
          MEM_DO = mem_rdata;
          ack_wait = 0;
        end else if (ce_now) ack_wait++;
      end
    end
  end

  // scoreboard monitor: checks memory requests and bus completions
  initial begin
    logic        prev_req, prev_rdy;
    logic [57:0] held;
    prev_req = 1'b0;
    prev_rdy = 1'b0;
    held = '0;
    forever begin
      @(negedge CLK);
      #2;
      if (RESn !== 1'b1) begin
        prev_req = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (req_any && !prev_req) begin
          if (exp_mem_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL mem_unexpected: got request %h expected none", obs);
          end else chk("mem_fields", obs, exp_mem_q.pop_front());
          held = obs;
        end else if (req_any) chk("mem_hold", obs, held);
        if (req_any) chk("readyn_hold", 64'(readyn_bus), 64'd1);
        if (prev_rdy && !readyn_bus) begin
          if (exp_rsp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rsp_unexpected: got completion D_O=%h expected none", do_bus);
          end else chk("read_data", do_bus, exp_rsp_q.pop_front());
        end
        prev_req = req_any;
        prev_rdy = readyn_bus;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus expected finish before 200000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // directed stimulus
  initial begin
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mem", {mem_req[i], mem_we[i], mem_a[i], mem_be[i], dbg[i]}, 64'h0);
      chk("rst_di", mem_di[i], 64'h0);
    end
    chk("rst_bus", {readyn_bus, szrq_bus, do_bus}, {1'b0, 1'b1, 32'h0});
    RESn = 1'b1;
    step();

    // DW=32 read, WS=0, immediate ACK
    bus_cycle("rd32", 32'hFFF0_0010, 4'h0, 1'b1, 32'h0, 32'hDEAD_BEEF, 0,
              {20'hC0004, 4'hF, 1'b0, 32'h0, 1'b1}, 32'hDEAD_BEEF, 2);
    // DW=32 write, WS=3
    bus_cycle("wr32_ws3", 32'hFFE0_0008, 4'b1100, 1'b0, 32'h1234_5678, 32'h0, 0,
              {20'h80002, 4'b0011, 1'b1, 32'h1234_5678, 1'b1}, 32'h0, 5);
    // DW=16 read, low halfword then high halfword
    bus_cycle("rd16_lo", 32'hFFD0_0006, 4'b1100, 1'b1, 32'h0, 32'h0000_ABCD, 0,
              {20'h80003, 4'b0011, 1'b0, 32'h0, 1'b0}, 32'hABCD_ABCD, 2);
    bus_cycle("rd16_hi", 32'hFFD0_0006, 4'b0011, 1'b1, 32'h0, 32'h0000_ABCD, 0,
              {20'h80003, 4'b0011, 1'b0, 32'h0, 1'b0}, 32'hABCD_ABCD, 2);
    // DW=16 write of the upper halfword lane
    bus_cycle("wr16_hi", 32'hFFD0_0004, 4'b0011, 1'b0, 32'hCAFE_1234, 32'h0, 0,
              {20'h80002, 4'b0011, 1'b1, 32'h0000_CAFE, 1'b0}, 32'h0, 2);

    // unselected address and I/O-space cycles
    idle_cycle("unsel_addr", 32'h0000_0100, 1'b0);
    idle_cycle("io_space", 32'hFFF0_0010, 1'b1);

    // delayed ACK with CE toggling
    ce_toggle = 1'b1;
    bus_cycle("rd32_slow", 32'hFFF0_0020, 4'h0, 1'b1, 32'h0, 32'h5A5A_0F0F, 5,
              {20'hC0008, 4'hF, 1'b0, 32'h0, 1'b1}, 32'h5A5A_0F0F, -1);
    ce_toggle = 1'b0;
    step();

    // reset while in REQ, then a late ACK that must be ignored
    resp_en = 1'b0;
    exp_mem_q.push_back({20'hC0010, 4'hF, 1'b0, 32'h0, 1'b1});
    wait_ce();
    A = 32'hFFF0_0040; BEn = 4'h0; RW = 1'b1; D_I = 32'h0; MRQn = 1'b0; BCYSTn = 1'b0;
    step();
    BCYSTn = 1'b1; MRQn = 1'b1; DAn = 1'b0;
    for (int k = 0; k < 10 && req_any !== 1'b1; k++) step();
    step();
    RESn = 1'b0;
    #1;
    chk("rst_mid_memreq", 64'(req_any), 64'd0);
    chk("rst_mid_readyn", 64'(readyn_bus), 64'd0);
    step();
    RESn = 1'b1; DAn = 1'b1;
    MEM_ACK = 1'b1;
    step();
    step();
    MEM_ACK = 1'b0;
    #1;
    chk("late_ack_ignored", {readyn_bus, req_any, dbg[0], do_bus}, 64'h0);
    resp_en = 1'b1;
    bus_cycle("wr32_after_rst", 32'hFFF0_0030, 4'h0, 1'b0, 32'hA5A5_5A5A, 32'h0, 0,
              {20'hC000C, 4'hF, 1'b1, 32'hA5A5_5A5A, 1'b1}, 32'h0, 2);

    repeat (4) step();
    chk("exp_mem_q_empty", 64'(exp_mem_q.size()), 64'd0);
    chk("exp_rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
